// File: rtl/xbar_master_arbiter.sv
// xbar_master_arbiter: shares one master port between the two slave-side
// port handlers, serialises their requests and steers read responses back.
//
// Ports:
//   aclk, areset            clock, asynchronous active-high reset
//   s_req/s_cmd             per-port request and command (1 = READ)
//   s0_/s1_addr, _wdata     per-port address and write data
//   s_ack, s_resp, s_rdata  per-port accept pulse, read response, read data
//   m_req/m_cmd/m_addr/
//   m_wdata                 latched request towards the master
//   m_ack, m_resp, m_rdata  master accept, read response, read data
//   err_resp                sticky: read response with nothing outstanding
//
// Config macro XBAR_ARB_RR_EN: defined = round-robin between the two ports,
// undefined = fixed priority with port 0 winning ties.
module xbar_master_arbiter #(
    parameter int AWIDTH   = 32,
    parameter int DWIDTH   = 32,
    parameter int RD_DEPTH = 4
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic [1:0]        s_req,
    input  logic [1:0]        s_cmd,
    input  logic [AWIDTH-1:0] s0_addr,
    input  logic [AWIDTH-1:0] s1_addr,
    input  logic [DWIDTH-1:0] s0_wdata,
    input  logic [DWIDTH-1:0] s1_wdata,
    output logic [1:0]        s_ack,
    output logic [1:0]        s_resp,
    output logic [DWIDTH-1:0] s_rdata,
    output logic              m_req,
    output logic              m_cmd,
    output logic [AWIDTH-1:0] m_addr,
    output logic [DWIDTH-1:0] m_wdata,
    input  logic              m_ack,
    input  logic              m_resp,
    input  logic [DWIDTH-1:0] m_rdata,
    output logic              err_resp
);

    localparam int PW = $clog2(RD_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {
        IDLE,
        BUSY
    } state_e;

    state_e              state_q, state_d;
    logic                g_q, g_d;
    logic                cmd_q, cmd_d;
    logic [AWIDTH-1:0]   addr_q, addr_d;
    logic [DWIDTH-1:0]   wdata_q, wdata_d;

    // Read-ID FIFO: one bit per entry holding the issuing port.
    logic [RD_DEPTH-1:0] ids_q;
    logic [PW-1:0]       wp_q;
    logic [PW-1:0]       rp_q;
    logic [CW-1:0]       cnt_q;
    logic                err_q;

    logic                rd_full;
    logic [1:0]          elig;
    logic                win;
    logic                push;
    logic                pop;

    // Eligibility uses the registered count only, so a same-cycle pop
    // never unblocks a read until the following cycle.
    assign rd_full = (cnt_q == CW'(RD_DEPTH));
    assign elig[0] = s_req[0] & (~s_cmd[0] | ~rd_full);
    assign elig[1] = s_req[1] & (~s_cmd[1] | ~rd_full);

`ifdef XBAR_ARB_RR_EN
    logic last_q, last_d;

    // On a tie the port that did not win last time goes first.
    assign win = (elig == 2'b11) ? ~last_q : elig[1];

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    // Only meaningful when some port is eligible: port 0 if it can go.
    assign win = ~elig[0];
`endif

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        cmd_d   = cmd_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        m_req   = 1'b0;
        s_ack   = 2'b00;
`ifdef XBAR_ARB_RR_EN
        last_d  = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (|elig) begin
                    state_d = BUSY;
                    g_d     = win;
                    cmd_d   = win ? s_cmd[1] : s_cmd[0];
                    addr_d  = win ? s1_addr : s0_addr;
                    wdata_d = win ? s1_wdata : s0_wdata;
`ifdef XBAR_ARB_RR_EN
                    last_d  = win;
`endif
                end
            end
            BUSY: begin
                m_req = 1'b1;
                if (m_ack) begin
                    state_d = IDLE;
                    s_ack   = g_q ? 2'b10 : 2'b01;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign push = (state_q == BUSY) & m_ack & cmd_q;
    assign pop  = m_resp & (cnt_q != '0);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q <= IDLE;
            g_q     <= 1'b0;
            cmd_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ids_q   <= '0;
            wp_q    <= '0;
            rp_q    <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            if (push) begin
                ids_q[wp_q] <= g_q;
                wp_q        <= wp_q + PW'(1);
            end
            if (pop) begin
                rp_q <= rp_q + PW'(1);
            end
            cnt_q <= cnt_q + CW'(push) - CW'(pop);
            if (m_resp && (cnt_q == '0)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign m_cmd    = cmd_q;
    assign m_addr   = addr_q;
    assign m_wdata  = wdata_q;
    assign s_resp   = pop ? (ids_q[rp_q] ? 2'b10 : 2'b01) : 2'b00;
    assign s_rdata  = m_rdata;
    assign err_resp = err_q;

endmodule

// File: tb/tb_xbar_master_arbiter.sv
// Self-checking bench for xbar_master_arbiter: vector table, directed
// corner sequences and a randomized run against a queue-based model.
module tb_xbar_master_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int RD = 4;

    logic          aclk;
    logic          areset;
    logic [1:0]    s_req;
    logic [1:0]    s_cmd;
    logic [AW-1:0] s0_addr;
    logic [AW-1:0] s1_addr;
    logic [DW-1:0] s0_wdata;
    logic [DW-1:0] s1_wdata;
    logic [1:0]    s_ack;
    logic [1:0]    s_resp;
    logic [DW-1:0] s_rdata;
    logic          m_req;
    logic          m_cmd;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic          m_ack;
    logic          m_resp;
    logic [DW-1:0] m_rdata;
    logic          err_resp;

    xbar_master_arbiter #(
        .AWIDTH  (AW),
        .DWIDTH  (DW),
        .RD_DEPTH(RD)
    ) dut (
        .aclk    (aclk),
        .areset  (areset),
        .s_req   (s_req),
        .s_cmd   (s_cmd),
        .s0_addr (s0_addr),
        .s1_addr (s1_addr),
        .s0_wdata(s0_wdata),
        .s1_wdata(s1_wdata),
        .s_ack   (s_ack),
        .s_resp  (s_resp),
        .s_rdata (s_rdata),
        .m_req   (m_req),
        .m_cmd   (m_cmd),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_ack   (m_ack),
        .m_resp  (m_resp),
        .m_rdata (m_rdata),
        .err_resp(err_resp)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [1:0] oh(input logic p);
        return p ? 2'b10 : 2'b01;
    endfunction

    task automatic step();
        @(posedge aclk);
        @(negedge aclk);
    endtask

    task automatic set_port(input logic p, input logic c,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        s_cmd[p] = c;
        if (p) begin
            s1_addr  = a;
            s1_wdata = d;
        end else begin
            s0_addr  = a;
            s0_wdata = d;
        end
        s_req[p] = 1'b1;
    endtask

    // One complete transaction from a single port, ack on first BUSY cycle.
    task automatic xact(input logic p, input logic c,
                        input logic [AW-1:0] a, input string nm);
        set_port(p, c, a, ~a);
        step();
        chk({nm, "_req"}, 64'(m_req), 64'(1'b1));
        chk({nm, "_addr"}, 64'(m_addr), 64'(a));
        m_ack = 1'b1;
        #1;
        chk({nm, "_ack"}, 64'(s_ack), 64'(oh(p)));
        step();
        s_req[p] = 1'b0;
        m_ack    = 1'b0;
    endtask

    task automatic resp(input logic [1:0] exp, input string nm);
        m_resp  = 1'b1;
        m_rdata = $urandom;
        #1;
        chk({nm, "_resp"}, 64'(s_resp), 64'(exp));
        chk({nm, "_rdat"}, 64'(s_rdata), 64'(m_rdata));
        step();
        m_resp = 1'b0;
    endtask

    typedef struct {
        logic [1:0] req;
        logic [1:0] cmd;
        logic       g_fx;
        logic       g_rr;
    } vec_t;

    vec_t vt[7];

    // Random-phase reference model state.
    logic          pend[2];
    logic          pcmd[2];
    logic [AW-1:0] paddr[2];
    logic [DW-1:0] pwd[2];
    logic          cool[2];
    logic          busy_m;
    logic          g_m;
    logic          ecmd;
    logic [AW-1:0] eaddr;
    logic [DW-1:0] ewd;
    logic          last_m;
    logic          q[$];

    initial begin
        vt[0] = '{req: 2'b11, cmd: 2'b00, g_fx: 1'b0, g_rr: 1'b0};
        vt[1] = '{req: 2'b11, cmd: 2'b11, g_fx: 1'b0, g_rr: 1'b1};
        vt[2] = '{req: 2'b10, cmd: 2'b10, g_fx: 1'b1, g_rr: 1'b1};
        vt[3] = '{req: 2'b11, cmd: 2'b01, g_fx: 1'b0, g_rr: 1'b0};
        vt[4] = '{req: 2'b01, cmd: 2'b01, g_fx: 1'b0, g_rr: 1'b0};
        vt[5] = '{req: 2'b11, cmd: 2'b10, g_fx: 1'b0, g_rr: 1'b1};
        vt[6] = '{req: 2'b11, cmd: 2'b11, g_fx: 1'b0, g_rr: 1'b0};

        areset   = 1'b1;
        s_req    = '0;
        s_cmd    = '0;
        s0_addr  = '0;
        s1_addr  = '0;
        s0_wdata = '0;
        s1_wdata = '0;
        m_ack    = 1'b0;
        m_resp   = 1'b0;
        m_rdata  = '0;
        #1;
        chk("rst_mreq", 64'(m_req), 64'(1'b0));
        chk("rst_mcmd", 64'(m_cmd), 64'(1'b0));
        chk("rst_addr", 64'(m_addr), 64'(0));
        chk("rst_wdat", 64'(m_wdata), 64'(0));
        chk("rst_err", 64'(err_resp), 64'(1'b0));
        chk("rst_ack", 64'(s_ack), 64'(0));
        @(negedge aclk);
        areset = 1'b0;

        // Vector table: grant choice, latched fields, ack and response.
        for (int i = 0; i < 7; i++) begin
            logic       g;
            logic       c;
            logic [AW-1:0] a;
`ifdef XBAR_ARB_RR_EN
            g = vt[i].g_rr;
`else
            g = vt[i].g_fx;
`endif
            s_cmd    = vt[i].cmd;
            s0_addr  = 32'h1000_0000 + i;
            s1_addr  = 32'h2000_0000 + i;
            s0_wdata = 32'hA000_0000 + i;
            s1_wdata = 32'hB000_0000 + i;
            s_req    = vt[i].req;
            c = g ? vt[i].cmd[1] : vt[i].cmd[0];
            a = g ? s1_addr : s0_addr;
            step();
            chk("v_req", 64'(m_req), 64'(1'b1));
            chk("v_cmd", 64'(m_cmd), 64'(c));
            chk("v_addr", 64'(m_addr), 64'(a));
            chk("v_wdat", 64'(m_wdata), 64'(g ? s1_wdata : s0_wdata));
            chk("v_noack", 64'(s_ack), 64'(0));
            m_ack = 1'b1;
            #1;
            chk("v_ack", 64'(s_ack), 64'(oh(g)));
            step();
            s_req = '0;
            m_ack = 1'b0;
            chk("v_idle", 64'(m_req), 64'(1'b0));
            if (c) resp(oh(g), "v");
        end

        // Single write from port 1, m_ack two cycles after m_req.
        set_port(1'b1, 1'b0, 32'h8000_0010, 32'hDEAD_BEEF);
        step();
        chk("w_req", 64'(m_req), 64'(1'b1));
        chk("w_addr", 64'(m_addr), 64'(32'h8000_0010));
        chk("w_wdat", 64'(m_wdata), 64'(32'hDEAD_BEEF));
        chk("w_ack0", 64'(s_ack), 64'(0));
        step();
        chk("w_hold", 64'(m_addr), 64'(32'h8000_0010));
        chk("w_ack1", 64'(s_ack), 64'(0));
        m_ack = 1'b1;
        #1;
        chk("w_ack", 64'(s_ack), 64'(2'b10));
        step();
        s_req = '0;
        m_ack = 1'b0;
        chk("w_done", 64'(m_req), 64'(1'b0));
        chk("w_ackx", 64'(s_ack), 64'(0));

        // Fill the read FIFO from port 0; a port 1 write must still pass.
        for (int i = 0; i < RD; i++) xact(1'b0, 1'b1, 32'h300 + i, "f");
        set_port(1'b0, 1'b1, 32'h0000_0404, 32'h0);
        set_port(1'b1, 1'b0, 32'h0000_0505, 32'h55);
        step();
        chk("f_wgnt", 64'(m_addr), 64'(32'h0000_0505));
        chk("f_wcmd", 64'(m_cmd), 64'(1'b0));
        m_ack = 1'b1;
        step();
        m_ack    = 1'b0;
        s_req[1] = 1'b0;
        step();
        chk("f_blk0", 64'(m_req), 64'(1'b0));
        step();
        chk("f_blk1", 64'(m_req), 64'(1'b0));
        resp(2'b01, "f_pop");
        chk("f_blk2", 64'(m_req), 64'(1'b0));
        step();
        chk("f_rgnt", 64'(m_req), 64'(1'b1));
        chk("f_raddr", 64'(m_addr), 64'(32'h0000_0404));
        m_ack = 1'b1;
        step();
        m_ack = 1'b0;
        s_req = '0;
        for (int i = 0; i < RD; i++) resp(2'b01, "f_dr");

        // Push and pop in the same cycle at count 2.
        xact(1'b0, 1'b1, 32'h600, "s0");
        xact(1'b1, 1'b1, 32'h601, "s1");
        set_port(1'b1, 1'b1, 32'h602, 32'h0);
        step();
        m_ack   = 1'b1;
        m_resp  = 1'b1;
        m_rdata = 32'h1234_5678;
        #1;
        chk("pp_ack", 64'(s_ack), 64'(2'b10));
        chk("pp_resp", 64'(s_resp), 64'(2'b01));
        step();
        m_ack  = 1'b0;
        m_resp = 1'b0;
        s_req  = '0;
        resp(2'b10, "pp1");
        resp(2'b10, "pp2");

        // Response with nothing outstanding: no steering, sticky error.
        chk("e_pre", 64'(err_resp), 64'(1'b0));
        resp(2'b00, "e");
        chk("e_set", 64'(err_resp), 64'(1'b1));
        step();
        step();
        chk("e_hold", 64'(err_resp), 64'(1'b1));

        // Reset while BUSY with two reads outstanding.
        xact(1'b0, 1'b1, 32'h700, "r0");
        xact(1'b1, 1'b1, 32'h701, "r1");
        set_port(1'b0, 1'b0, 32'h702, 32'h0);
        step();
        chk("r_busy", 64'(m_req), 64'(1'b1));
        #2;
        areset = 1'b1;
        #1;
        chk("r_mreq", 64'(m_req), 64'(1'b0));
        chk("r_err", 64'(err_resp), 64'(1'b0));
        chk("r_addr", 64'(m_addr), 64'(0));
        @(negedge aclk);
        areset = 1'b0;
        set_port(1'b0, 1'b0, 32'h800, 32'h0);
        set_port(1'b1, 1'b0, 32'h801, 32'h0);
        step();
        chk("r_gnt0", 64'(m_addr), 64'(32'h800));
        m_ack = 1'b1;
        step();
        m_ack = 1'b0;
        s_req = '0;
        resp(2'b00, "r_emp");
        areset = 1'b1;
        #1;
        chk("r_err2", 64'(err_resp), 64'(1'b0));
        @(negedge aclk);
        areset = 1'b0;

        // Randomized run against the transaction-level model.
        for (int p = 0; p < 2; p++) begin
            pend[p] = 1'b0;
            cool[p] = 1'b0;
            pcmd[p] = 1'b0;
            paddr[p] = '0;
            pwd[p] = '0;
        end
        busy_m = 1'b0;
        g_m    = 1'b0;
        ecmd   = 1'b0;
        eaddr  = '0;
        ewd    = '0;
        last_m = 1'b1;
        q.delete();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic [1:0] el;
            logic       w;
            logic       acked;
            logic       popped;
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && !cool[p] && $urandom_range(0, 2) != 0) begin
                    pend[p]  = 1'b1;
                    pcmd[p]  = 1'($urandom_range(0, 1));
                    paddr[p] = $urandom;
                    pwd[p]   = $urandom;
                end
                cool[p] = 1'b0;
            end
            s_req    = {pend[1], pend[0]};
            s_cmd    = {pcmd[1], pcmd[0]};
            s0_addr  = paddr[0];
            s1_addr  = paddr[1];
            s0_wdata = pwd[0];
            s1_wdata = pwd[1];
            m_ack    = 1'($urandom_range(0, 1));
            m_resp   = (q.size() > 0) && ($urandom_range(0, 2) == 0);
            m_rdata  = $urandom;
            #1;
            acked  = busy_m && m_ack;
            popped = m_resp && (q.size() > 0);
            chk("x_ack", 64'(s_ack), 64'(acked ? oh(g_m) : 2'b00));
            chk("x_resp", 64'(s_resp), 64'(popped ? oh(q[0]) : 2'b00));
            chk("x_mreq", 64'(m_req), 64'(busy_m));
            chk("x_err", 64'(err_resp), 64'(1'b0));
            if (busy_m) begin
                chk("x_cmd", 64'(m_cmd), 64'(ecmd));
                chk("x_addr", 64'(m_addr), 64'(eaddr));
                chk("x_wdat", 64'(m_wdata), 64'(ewd));
            end
            for (int p = 0; p < 2; p++)
                el[p] = pend[p] && (!pcmd[p] || q.size() < RD);
            if (popped) void'(q.pop_front());
            if (acked) begin
                busy_m = 1'b0;
                if (ecmd) q.push_back(g_m);
                pend[g_m] = 1'b0;
                cool[g_m] = 1'b1;
            end else if (!busy_m && el != 2'b00) begin
`ifdef XBAR_ARB_RR_EN
                w = (el == 2'b11) ? !last_m : el[1];
`else
                w = (el == 2'b11) ? 1'b0 : el[1];
`endif
                last_m = w;
                busy_m = 1'b1;
                g_m    = w;
                ecmd   = pcmd[w];
                eaddr  = paddr[w];
                ewd    = pwd[w];
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/xbar_master_arbiter.md
# xbar_master_arbiter

Per-master arbiter of the two-port cross bar. It sits in front of one master port and shares it between the two slave-side port handlers (port 0, port 1), which present read or write requests routed to this master. It serialises requests with a req/ack handshake and remembers the issuing port of each outstanding read. Read responses are steered back to the port that issued the read.

## Interface
- AWIDTH, 32, address width
- DWIDTH, 32, data width
- RD_DEPTH, 4, max outstanding reads (power of 2, ≥2)

- aclk  in  1  clock
- areset  in  1  asynchronous active-high reset
- s_req  in  2  request per port, bit i = port i
- s_cmd  in  2  per port: 1 = READ, 0 = WRITE
- s0_addr, s1_addr  in  AWIDTH  port addresses
- s0_wdata, s1_wdata  in  DWIDTH  port write data
- s_ack  out  2  one-cycle accept pulse per port
- s_resp  out  2  one-cycle read-response pulse per port
- s_rdata  out  DWIDTH  read data, valid with any s_resp bit
- m_req  out  1  master request
- m_cmd  out  1  latched cmd of granted port
- m_addr  out  AWIDTH  latched address
- m_wdata  out  DWIDTH  latched write data
- m_ack  in  1  master accepts current request
- m_resp  in  1  master read-response pulse
- m_rdata  in  DWIDTH  master read data
- err_resp  out  1  sticky: response with no outstanding read

## Operation
- FSM states:
  - IDLE: evaluate eligible requests; on grant latch cmd/addr/wdata of winner into m_*, set grant id g → BUSY.
  - BUSY: m_req=1, m_cmd/m_addr/m_wdata held stable; on m_ack → IDLE.
- Eligibility: port i eligible = s_req[i] & (s_cmd[i]==0 | !rd_full). A blocked read never stalls an eligible write on the other port.
- Arbitration: round-robin (see Configuration).
  - last_grant register; when both ports are eligible, the port ≠ last_grant wins.
  - last_grant updates on each grant; reset value 1, so port 0 wins first.
- s_ack[g] = m_ack & BUSY (combinational, zero latency). The other s_ack bit stays 0.
- Requester rule: a requester holds s_req, cmd, addr and wdata until it sees s_ack, then deasserts s_req in the following cycle.
- Read tracking: ID FIFO, RD_DEPTH entries, 1-bit port ID.
  - Push g on m_ack when m_cmd=1.
  - rd_full = count==RD_DEPTH; count width clog2(RD_DEPTH)+1.
  - On m_resp with FIFO non-empty: pop, s_resp[head]=1 for that cycle (combinational), s_rdata=m_rdata.
  - On m_resp with FIFO empty: no s_resp, err_resp set, held until reset.
  - Simultaneous push and pop: both happen, count unchanged. Allowed at full; the pop frees a slot but eligibility uses the registered count.
- s_rdata = m_rdata continuously; it is meaningful only with s_resp.
- Reset values (asynchronous, also mid-transaction): state IDLE, m_req 0, m_cmd 0, m_addr 0, m_wdata 0, last_grant 1, FIFO empty, err_resp 0. s_ack and s_resp are 0 since derived. Any in-flight request is dropped; requesters re-issue.

## Timing
- Grant latency: s_req high in IDLE at edge N → m_req=1 and m_* valid after edge N.
- m_ack sampled high at edge M → s_ack pulses in cycle before M, FSM in IDLE after M, m_req=0 after M.
- Minimum one IDLE cycle between back-to-back grants; peak throughput one request per 2 cycles with m_ack tied high.
- Read response: s_resp in the same cycle as m_resp (zero latency). Responses return in issue order.

## Configuration
- XBAR_ARB_RR_EN defined: round-robin as above.
- XBAR_ARB_RR_EN undefined: fixed priority, port 0 always wins when both are eligible. last_grant is not implemented. All other behaviour is identical.

## Test plan
- Single write, port 1, addr 0x8000_0010, wdata 0xDEAD_BEEF, m_ack 2 cycles after m_req → m_addr/m_wdata match, s_ack=2'b10 for one cycle, no FIFO push.
- Both ports request reads continuously, m_ack tied 1, m_resp returned 3 cycles after each ack → grants alternate 0,1,0,1 (RR). With RR disabled, port 0 wins every grant while its s_req stays high. s_resp order matches grant order.
- RD_DEPTH=4, port 0 issues 4 reads with no m_resp; port 0 5th read pending plus port 1 write → write granted, read held until one m_resp pops.
- m_resp and read m_ack in the same cycle at count 2 → count stays 2, head ID routed correctly.
- m_resp with empty FIFO → s_resp=0, err_resp=1 and remains 1 until areset.
- areset pulsed while BUSY with 2 reads outstanding → m_req=0 immediately, FIFO empty, next grant goes to port 0.
